// File: rtl/icache_if.sv
// ---------------------------------------------------------------------------
// icache_if
// Bundles the fetch-side (CPU) and fill-side (coherence controller) signals
// of one instruction cache.
//   imemREN  : CPU fetch request
//   imemaddr : CPU fetch address (bits[1:0] ignored)
//   flush    : invalidate every entry
//   ihit     : imemload valid this cycle
//   imemload : instruction returned to the CPU
//   iREN     : fill request to the coherence controller
//   iaddr    : fill address to the coherence controller
//   iwait    : low when iload is valid / the fill is granted
//   iload    : fill data from the coherence controller
// Modports:
//   master : the environment (CPU + controller) driving the cache
//   slave  : the cache itself
// ---------------------------------------------------------------------------
interface icache_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        flush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport master (
        output imemREN, imemaddr, flush, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

    modport slave (
        input  imemREN, imemaddr, flush, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache
// Direct-mapped, read-only L1 instruction cache. Hits are answered in the
// same cycle; a miss issues a one-word fill to the coherence controller and
// the refetch hits on the cycle after the fill completes.
// Ports:
//   CLK  : system clock, rising edge
//   nRST : asynchronous active-low reset
//   bus  : icache_if.slave (CPU fetch side and controller fill side)
// Parameters:
//   SETS : number of entries, power of 2
// ---------------------------------------------------------------------------
module icache #(
    parameter int SETS = 16
) (
    input  logic      CLK,
    input  logic      nRST,
    icache_if.slave   bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t            r_state;
    logic [SETS-1:0]   r_valid;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [31:0]       r_data [SETS];
    logic              r_iren;
    logic [31:0]       r_iaddr;
    logic              r_flushPend;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_fillIdx;
    logic [TAG_W-1:0]  w_fillTag;
    logic              w_hit;
    logic              w_fillDone;

    assign w_idx     = bus.imemaddr[IDX_W+1:2];
    assign w_tag     = bus.imemaddr[31:IDX_W+2];
    // The fill target comes from the registered miss address, so the CPU may
    // move imemaddr freely while the fill is outstanding.
    assign w_fillIdx = r_iaddr[IDX_W+1:2];
    assign w_fillTag = r_iaddr[31:IDX_W+2];

    // A flush in the same cycle suppresses the hit.
    assign w_hit = (r_state == IDLE) && bus.imemREN && !bus.flush &&
                   r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    assign w_fillDone = (r_state == FETCH) && !bus.iwait;

    assign bus.ihit     = w_hit;
    assign bus.imemload = w_hit ? r_data[w_idx] : 32'd0;
    assign bus.iREN     = r_iren;
    assign bus.iaddr    = r_iaddr;

    // r_flushPend remembers a flush seen earlier in the current fill so the
    // fill data is written but never marked valid.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_iren      <= 1'b0;
            r_iaddr     <= 32'd0;
            r_flushPend <= 1'b0;
            for (int i = 0; i < SETS; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.flush) begin
                        r_valid <= '0;
                    end else if (bus.imemREN && !w_hit) begin
                        r_state     <= FETCH;
                        r_iren      <= 1'b1;
                        r_iaddr     <= {bus.imemaddr[31:2], 2'b00};
                        r_flushPend <= 1'b0;
                    end
                end
                FETCH: begin
                    if (bus.flush) begin
                        r_valid <= '0;
                    end
                    if (w_fillDone) begin
                        r_tag[w_fillIdx]  <= w_fillTag;
                        r_data[w_fillIdx] <= bus.iload;
                        if (!bus.flush && !r_flushPend) begin
                            r_valid[w_fillIdx] <= 1'b1;
                        end
                        r_state     <= IDLE;
                        r_iren      <= 1'b0;
                        r_iaddr     <= 32'd0;
                        r_flushPend <= 1'b0;
                    end else if (bus.flush) begin
                        r_flushPend <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_iren  <= 1'b0;
                    r_iaddr <= 32'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_icache.sv
// ---------------------------------------------------------------------------
// tb_icache
// Self-checking bench for icache. A word-address reference model (one slot
// per index holding valid, word address and data) predicts hits, returned
// data and the fill handshake for directed and random fetch sequences.
// ---------------------------------------------------------------------------
module tb_icache;
    logic CLK;
    logic nRST;

    icache_if ifc ();

    icache #(.SETS(16)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (ifc.slave)
    );

    int checks;
    int errors;

    bit          mValid [16];
    logic [29:0] mLine  [16];
    logic [31:0] mData  [16];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void modelClear();
        for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
    endfunction

    function automatic bit modelHit(input logic [31:0] a);
        return mValid[a[5:2]] && (mLine[a[5:2]] == a[31:2]);
    endfunction

    // Issue one fetch of addr. On a miss, hold iwait high for `waits`
    // cycles then deliver data. Optionally pulse flush in the first FETCH
    // cycle and/or switch imemaddr to altAddr during the fill.
    task automatic doFetch(input logic [31:0] addr, input int waits,
                           input logic [31:0] data, input bit flushMid,
                           input bit changeAddr, input logic [31:0] altAddr,
                           input string name);
        bit          expHit;
        logic [31:0] cur;
        logic [31:0] lineAddr;
        lineAddr = {addr[31:2], 2'b00};
        @(negedge CLK);
        ifc.imemREN  = 1'b1;
        ifc.imemaddr = addr;
        ifc.flush    = 1'b0;
        ifc.iwait    = 1'b1;
        #2;
        expHit = modelHit(addr);
        checks++;
        if (ifc.ihit !== expHit) begin
            errors++;
            $display("[TB] FAIL %s lookup ihit: got %0b expected %0b (addr %h)", name, ifc.ihit, expHit, addr);
        end
        checks++;
        if (ifc.imemload !== (expHit ? mData[addr[5:2]] : 32'd0)) begin
            errors++;
            $display("[TB] FAIL %s lookup imemload: got %h expected %h", name, ifc.imemload, expHit ? mData[addr[5:2]] : 32'd0);
        end
        if (expHit) begin
            checks++;
            if (ifc.iREN !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s hit iREN: got %0b expected 0", name, ifc.iREN);
            end
            #1 ifc.imemREN = 1'b0;
            return;
        end
        for (int c = 0; c <= waits; c++) begin
            @(negedge CLK);
            if (changeAddr) ifc.imemaddr = altAddr;
            ifc.iwait = (c < waits);
            ifc.iload = (c < waits) ? $urandom : data;
            ifc.flush = flushMid && (c == 0);
            #2;
            checks++;
            if (ifc.iREN !== 1'b1 || ifc.iaddr !== lineAddr || ifc.ihit !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s fetch cycle %0d: iREN=%0b iaddr=%h ihit=%0b expected 1/%h/0", name, c, ifc.iREN, ifc.iaddr, ifc.ihit, lineAddr);
            end
        end
        if (flushMid) begin
            modelClear();
        end else begin
            mValid[addr[5:2]] = 1'b1;
            mLine[addr[5:2]]  = addr[31:2];
            mData[addr[5:2]]  = data;
        end
        @(negedge CLK);
        ifc.flush = 1'b0;
        ifc.iwait = 1'b1;
        #2;
        cur    = ifc.imemaddr;
        expHit = modelHit(cur);
        checks++;
        if (ifc.iREN !== 1'b0 || ifc.iaddr !== 32'd0) begin
            errors++;
            $display("[TB] FAIL %s after fill: iREN=%0b iaddr=%h expected 0/0", name, ifc.iREN, ifc.iaddr);
        end
        checks++;
        if (ifc.ihit !== expHit || ifc.imemload !== (expHit ? mData[cur[5:2]] : 32'd0)) begin
            errors++;
            $display("[TB] FAIL %s refetch: ihit=%0b imemload=%h expected %0b/%h", name, ifc.ihit, ifc.imemload, expHit, expHit ? mData[cur[5:2]] : 32'd0);
        end
        #1 ifc.imemREN = 1'b0;
    endtask

    task automatic test_reset();
        ifc.imemREN = 1'b0; ifc.imemaddr = 32'd0; ifc.flush = 1'b0;
        ifc.iwait = 1'b1; ifc.iload = 32'd0;
        nRST = 1'b0;
        modelClear();
        repeat (2) @(negedge CLK);
        #2;
        checks++;
        if (ifc.ihit !== 1'b0 || ifc.imemload !== 32'd0 || ifc.iREN !== 1'b0 || ifc.iaddr !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset outputs: ihit=%0b imemload=%h iREN=%0b iaddr=%h expected all 0", ifc.ihit, ifc.imemload, ifc.iREN, ifc.iaddr);
        end
        nRST = 1'b1;
        @(negedge CLK);
        ifc.imemREN = 1'b1; ifc.imemaddr = 32'd0;
        #2;
        checks++;
        if (ifc.ihit !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset addr0 must miss: ihit=%0b expected 0", ifc.ihit);
        end
        ifc.imemREN = 1'b0;
        #1;
    endtask

    task automatic test_coldMiss();
        doFetch(32'h0000_0040, 3, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0, "cold_miss");
    endtask

    task automatic test_hit();
        doFetch(32'h0000_0040, 0, 32'h0, 1'b0, 1'b0, 32'd0, "hit");
    endtask

    task automatic test_conflict();
        doFetch(32'h0000_0080, 1, 32'h1111_1111, 1'b0, 1'b0, 32'd0, "conflict_fill");
        doFetch(32'h0000_0040, 0, 32'h2222_2222, 1'b0, 1'b0, 32'd0, "conflict_evicted");
    endtask

    task automatic test_addrChange();
        doFetch(32'h0000_0100, 2, 32'h3333_3333, 1'b0, 1'b1, 32'h0000_0104, "addr_change");
        doFetch(32'h0000_0104, 1, 32'h4444_4444, 1'b0, 1'b0, 32'd0, "addr_change_new");
    endtask

    task automatic test_flushFetch();
        doFetch(32'h0000_0200, 2, 32'h5555_5555, 1'b1, 1'b0, 32'd0, "flush_fetch");
        doFetch(32'h0000_0200, 0, 32'h6666_6666, 1'b0, 1'b0, 32'd0, "flush_refetch");
        doFetch(32'h0000_0104, 0, 32'h7777_7777, 1'b0, 1'b0, 32'd0, "flush_prior");
    endtask

    task automatic test_flushIdle();
        @(negedge CLK);
        ifc.imemREN = 1'b1; ifc.imemaddr = 32'h0000_0104; ifc.flush = 1'b1;
        #2;
        checks++;
        if (ifc.ihit !== 1'b0 || ifc.imemload !== 32'd0) begin
            errors++;
            $display("[TB] FAIL flush_idle suppress: ihit=%0b imemload=%h expected 0/0", ifc.ihit, ifc.imemload);
        end
        modelClear();
        @(negedge CLK);
        ifc.imemREN = 1'b0; ifc.flush = 1'b0;
        #2;
        checks++;
        if (ifc.iREN !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_idle no miss: iREN=%0b expected 0", ifc.iREN);
        end
        doFetch(32'h0000_0104, 0, 32'h8888_8888, 1'b0, 1'b0, 32'd0, "flush_idle_refetch");
    endtask

    task automatic test_resetMidFetch();
        @(negedge CLK);
        ifc.imemREN = 1'b1; ifc.imemaddr = 32'h0000_0300; ifc.iwait = 1'b1;
        @(negedge CLK);
        #2;
        checks++;
        if (ifc.iREN !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid pre: iREN=%0b expected 1", ifc.iREN);
        end
        #1 nRST = 1'b0;
        #1;
        checks++;
        if (ifc.iREN !== 1'b0 || ifc.iaddr !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid async: iREN=%0b iaddr=%h expected 0/0", ifc.iREN, ifc.iaddr);
        end
        modelClear();
        ifc.imemREN = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        doFetch(32'h0000_0040, 1, 32'h9999_9999, 1'b0, 1'b0, 32'd0, "reset_mid_refetch");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        for (int n = 0; n < 60; n++) begin
            a = {24'd0, 2'(($urandom_range(0, 2))), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            b = {24'd0, 2'(($urandom_range(0, 2))), 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 9) == 0) begin
                @(negedge CLK);
                ifc.imemREN = 1'($urandom_range(0, 1)); ifc.imemaddr = a; ifc.flush = 1'b1;
                #2;
                checks++;
                if (ifc.ihit !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL random flush ihit: got %0b expected 0", ifc.ihit);
                end
                modelClear();
                #1 ifc.imemREN = 1'b0;
                @(negedge CLK);
                ifc.flush = 1'b0;
            end else begin
                doFetch(a, $urandom_range(0, 3), $urandom, ($urandom_range(0, 7) == 0),
                        ($urandom_range(0, 3) == 0), b, "random");
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_coldMiss();
        test_hit();
        test_conflict();
        test_addrChange();
        test_flushFetch();
        test_flushIdle();
        test_resetMidFetch();
        test_random();
        repeat (2) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
